// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port among NREQ requesters, with grant locking
//   clk, rst                : clock, synchronous active-high reset
//   m_req/m_wr/m_lock       : per-requester request, write select, keep-grant request
//   m_addr/m_dout           : packed per-requester address and write data
//   m_din, m_rdy            : broadcast read data, per-requester completion pulse
//   grant                   : one-hot current owner of the memory port
//   req/wr/addr/dout        : memory-side request
//   din/rdy                 : memory read data and completion pulse
//   lock_timeout, txn_cnt   : held-lock expiry pulse, completed-transaction count
module mem_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int LOCK_TO = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    m_req,
    input  logic [NREQ-1:0]    m_wr,
    input  logic [NREQ-1:0]    m_lock,
    input  logic [NREQ*AW-1:0] m_addr,
    input  logic [NREQ*DW-1:0] m_dout,
    output logic [DW-1:0]      m_din,
    output logic [NREQ-1:0]    m_rdy,
    output logic [NREQ-1:0]    grant,
    output logic               req,
    output logic               wr,
    output logic [AW-1:0]      addr,
    output logic [DW-1:0]      dout,
    input  logic [DW-1:0]      din,
    input  logic               rdy,
    output logic               lock_timeout,
    output logic [31:0]        txn_cnt
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(LOCK_TO + 1);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d, m_rdy_q, m_rdy_d, mreq;
    logic              req_q, req_d, wr_q, wr_d, lock_q, lock_d, lt_q, lt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     dout_q, dout_d, m_din_q, m_din_d;
    logic [31:0]       txn_q, txn_d;
    logic [IW-1:0]     g_q, g_d, last_q, last_d, win_idx, sel;
    logic [CW-1:0]     hold_q, hold_d;
    logic              win_ok, go;

    always_comb begin
        // A requester still seeing its own completion pulse has not yet dropped the old request
        mreq = m_req & ~m_rdy_q;
        win_ok = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NREQ; k++)
            if (!win_ok && mreq[(int'(last_q) + k) % NREQ]) begin
                win_ok = 1'b1;
                win_idx = IW'((int'(last_q) + k) % NREQ);
            end
        sel = (state_q == HOLD) ? g_q : win_idx;
        go = (state_q == IDLE && win_ok) || (state_q == HOLD && mreq[g_q]);
        state_d = state_q;
        grant_d = grant_q;
        m_rdy_d = '0;
        req_d = req_q;
        wr_d = wr_q;
        lock_d = lock_q;
        lt_d = 1'b0;
        addr_d = addr_q;
        dout_d = dout_q;
        m_din_d = m_din_q;
        txn_d = txn_q;
        g_d = g_q;
        last_d = last_q;
        hold_d = hold_q;
        if (go) begin
            state_d = BUSY;
            grant_d = NREQ'(1) << sel;
            g_d = sel;
            req_d = 1'b1;
            wr_d = m_wr[sel];
            lock_d = m_lock[sel];
            addr_d = m_addr[int'(sel)*AW +: AW];
            dout_d = m_dout[int'(sel)*DW +: DW];
        end else if (state_q == BUSY && rdy) begin
            req_d = 1'b0;
            m_din_d = wr_q ? m_din_q : din;
            m_rdy_d = NREQ'(1) << g_q;
            last_d = g_q;
            txn_d = txn_q + 32'd1;
            hold_d = '0;
            state_d = lock_q ? HOLD : IDLE;
            grant_d = lock_q ? grant_q : '0;
        end else if (state_q == HOLD) begin
            // A request in the expiry cycle wins because go is tested first
            lt_d = (hold_q == CW'(LOCK_TO - 1));
            state_d = lt_d ? IDLE : HOLD;
            grant_d = lt_d ? '0 : grant_q;
            hold_d = lt_d ? '0 : hold_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            m_rdy_q <= '0;
            req_q <= 1'b0;
            wr_q <= 1'b0;
            lock_q <= 1'b0;
            lt_q <= 1'b0;
            addr_q <= '0;
            dout_q <= '0;
            m_din_q <= '0;
            txn_q <= '0;
            g_q <= '0;
            last_q <= IW'(NREQ - 1);
            hold_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            m_rdy_q <= m_rdy_d;
            req_q <= req_d;
            wr_q <= wr_d;
            lock_q <= lock_d;
            lt_q <= lt_d;
            addr_q <= addr_d;
            dout_q <= dout_d;
            m_din_q <= m_din_d;
            txn_q <= txn_d;
            g_q <= g_d;
            last_q <= last_d;
            hold_q <= hold_d;
        end
    end

    assign grant = grant_q;
    assign m_rdy = m_rdy_q;
    assign req = req_q;
    assign wr = wr_q;
    assign addr = addr_q;
    assign dout = dout_q;
    assign m_din = m_din_q;
    assign txn_cnt = txn_q;
    assign lock_timeout = lt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   m_req = '0, m_wr = '0, m_lock = '0;
    logic [255:0] m_addr = '0, m_dout = '0;
    logic [63:0]  m_din, addr, dout;
    logic [63:0]  din = '0;
    logic [3:0]   m_rdy, grant;
    logic         req, wr, rdy = 1'b0, lock_timeout;
    logic [31:0]  txn_cnt;
    int           checks = 0, fails = 0;

    mem_port_arbiter #(.NREQ(4), .AW(64), .DW(64), .LOCK_TO(16)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_lock(m_lock),
        .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din), .m_rdy(m_rdy),
        .grant(grant), .req(req), .wr(wr), .addr(addr), .dout(dout),
        .din(din), .rdy(rdy), .lock_timeout(lock_timeout), .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_done(input logic [63:0] d);
        rdy = 1'b1;
        din = d;
        tick();
        rdy = 1'b0;
        din = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_req = '0;
        m_lock = '0;
        m_wr = '0;
        tick();
        rst = 1'b0;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int pulses;

    initial begin
        tick();
        tick();
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_req", 64'(req), 64'h0);
        chk("rst_mrdy", 64'(m_rdy), 64'h0);
        chk("rst_txn", 64'(txn_cnt), 64'h0);
        chk("rst_lto", 64'(lock_timeout), 64'h0);
        chk("rst_addr", addr, 64'h0);
        chk("rst_mdin", m_din, 64'h0);
        rst = 1'b0;

        // single read by requester 2
        m_req[2] = 1'b1;
        m_addr[2*64 +: 64] = 64'h1fff;
        tick();
        chk("rd_req", 64'(req), 64'h1);
        chk("rd_grant", 64'(grant), 64'h4);
        chk("rd_addr", addr, 64'h1fff);
        chk("rd_wr", 64'(wr), 64'h0);
        tick();
        tick();
        chk("rd_req_hold", 64'(req), 64'h1);
        chk("rd_addr_hold", addr, 64'h1fff);
        mem_done(64'hDEADBEEF_00000001);
        chk("rd_mrdy", 64'(m_rdy), 64'h4);
        chk("rd_mdin", m_din, 64'hDEADBEEF_00000001);
        chk("rd_txn", 64'(txn_cnt), 64'h1);
        chk("rd_req_low", 64'(req), 64'h0);
        chk("rd_grant_low", 64'(grant), 64'h0);
        m_req[2] = 1'b0;
        tick();
        chk("rd_mrdy_once", 64'(m_rdy), 64'h0);

        // all four requesting reads, requester 0 re-requests
        do_reset();
        for (int i = 0; i < 4; i++) m_addr[i*64 +: 64] = 64'(i * 256);
        m_req = 4'hF;
        tick();
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("rr_grant%0d", n), 64'(grant), 64'(4'b1 << order[n]));
            chk($sformatf("rr_addr%0d", n), addr, 64'(order[n] * 256));
            mem_done(64'(n + 100));
            chk($sformatf("rr_mrdy%0d", n), 64'(m_rdy), 64'(4'b1 << order[n]));
            chk($sformatf("rr_din%0d", n), m_din, 64'(n + 100));
            if (order[n] != 0 || n == 4) m_req[order[n]] = 1'b0;
            chk($sformatf("rr_reqlow%0d", n), 64'(req), 64'h0);
            tick();
        end
        chk("rr_txn", 64'(txn_cnt), 64'd5);
        chk("rr_idle", 64'(grant), 64'h0);

        // locked read-modify-write by requester 1 while requester 3 waits
        do_reset();
        m_addr[1*64 +: 64] = 64'h10;
        m_addr[3*64 +: 64] = 64'h30;
        m_lock[1] = 1'b1;
        m_req = 4'b1010;
        tick();
        chk("rmw_grant_rd", 64'(grant), 64'h2);
        chk("rmw_addr_rd", addr, 64'h10);
        mem_done(64'h55);
        chk("rmw_mrdy_rd", 64'(m_rdy), 64'h2);
        chk("rmw_hold_grant", 64'(grant), 64'h2);
        m_wr[1] = 1'b1;
        m_dout[1*64 +: 64] = 64'h56;
        m_lock[1] = 1'b0;
        tick();
        chk("rmw_hold_req", 64'(req), 64'h0);
        chk("rmw_hold_grant2", 64'(grant), 64'h2);
        tick();
        chk("rmw_wr_req", 64'(req), 64'h1);
        chk("rmw_wr", 64'(wr), 64'h1);
        chk("rmw_wr_addr", addr, 64'h10);
        chk("rmw_wr_data", dout, 64'h56);
        chk("rmw_wr_grant", 64'(grant), 64'h2);
        mem_done(64'h0);
        chk("rmw_wr_mdin_kept", m_din, 64'h55);
        chk("rmw_wr_grant0", 64'(grant), 64'h0);
        m_req[1] = 1'b0;
        tick();
        chk("rmw_r3_grant", 64'(grant), 64'h8);
        chk("rmw_r3_addr", addr, 64'h30);
        mem_done(64'h7);
        chk("rmw_txn", 64'(txn_cnt), 64'd3);
        m_req[3] = 1'b0;
        tick();

        // lock expiry with requester 2 pending
        do_reset();
        m_addr[0] = '0;
        m_addr[0*64 +: 64] = 64'h40;
        m_addr[2*64 +: 64] = 64'h22;
        m_lock[0] = 1'b1;
        m_req[0] = 1'b1;
        tick();
        chk("lto_grant0", 64'(grant), 64'h1);
        m_req[2] = 1'b1;
        m_lock[2] = 1'b1;
        mem_done(64'h99);
        m_req[0] = 1'b0;
        m_lock[0] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (lock_timeout) pulses++;
            tick();
        end
        if (lock_timeout) pulses++;
        chk("lto_early", 64'(pulses), 64'h0);
        chk("lto_hold_grant", 64'(grant), 64'h1);
        tick();
        chk("lto_pulse", 64'(lock_timeout), 64'h1);
        chk("lto_grant_off", 64'(grant), 64'h0);
        tick();
        chk("lto_pulse_once", 64'(lock_timeout), 64'h0);
        chk("lto_r2_grant", 64'(grant), 64'h4);
        chk("lto_r2_addr", addr, 64'h22);
        mem_done(64'h1);
        m_req[2] = 1'b0;
        m_lock[2] = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        m_req[2] = 1'b1;
        tick();
        chk("lto_tie_nopulse", 64'(lock_timeout), 64'h0);
        chk("lto_tie_req", 64'(req), 64'h1);
        chk("lto_tie_grant", 64'(grant), 64'h4);
        mem_done(64'h2);
        m_req[2] = 1'b0;
        tick();
        chk("lto_tie_idle", 64'(grant), 64'h0);

        // reset during BUSY
        do_reset();
        m_req[1] = 1'b1;
        tick();
        chk("rb_req", 64'(req), 64'h1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rb_req_off", 64'(req), 64'h0);
        chk("rb_grant_off", 64'(grant), 64'h0);
        rst = 1'b0;
        m_req[1] = 1'b0;
        mem_done(64'hABC);
        chk("rb_no_mrdy", 64'(m_rdy), 64'h0);
        chk("rb_txn", 64'(txn_cnt), 64'h0);
        chk("rb_mdin", m_din, 64'h0);
        chk("rb_grant", 64'(grant), 64'h0);
        m_req = 4'b0011;
        tick();
        chk("rb_first_r0", 64'(grant), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
